// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_e : controller state encoding (2 bits)
//   DEF_*         : default widths, latency, buffer depth and reset PC
//   cnt_width()   : bits needed to hold a count of 0..n
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_e;

    localparam int          DEF_ADDR_W    = 32;
    localparam int          DEF_DATA_W    = 32;
    localparam int          DEF_MEM_LAT   = 2;
    localparam int          DEF_PC_STEP   = 1;
    localparam int          DEF_BUF_DEPTH = 4;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory and decode-side bus of the fetch controller.
//   imem_pc    : word address presented to instruction memory
//   imem_rdata : word for the address presented MEM_LAT cycles earlier
//   ins_valid / ins_ready : decode handshake
//   ins_data / ins_pc     : instruction at the buffer head and its PC
// master = fetch controller, slave = memory/decode side.
interface fetch_controller_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] imem_pc;
    logic [DATA_W-1:0] imem_rdata;
    logic              ins_valid;
    logic              ins_ready;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;

    modport master (
        output imem_pc,
        input  imem_rdata,
        output ins_valid,
        input  ins_ready,
        output ins_data,
        output ins_pc
    );

    modport slave (
        input  imem_pc,
        output imem_rdata,
        input  ins_valid,
        output ins_ready,
        input  ins_data,
        input  ins_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering returned instruction words for decode.
//   clk, rst  : clock, synchronous active-low reset
//   push_i    : write wdata_i (ignored when full unless popping)
//   pop_i     : drop the head entry (ignored when empty)
//   flush_i   : empty the FIFO; wins over a same-cycle push
//   rdata_o   : head entry (undefined when count_o == 0)
//   count_o   : registered occupancy
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int WIDTH = DEF_DATA_W + DEF_ADDR_W,
    parameter  int DEPTH = DEF_BUF_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is not reset; the occupancy count qualifies every read.
    always_ff @(posedge clk) begin
        if (rst && do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, issues one word fetch per cycle
// into a MEM_LAT-deep memory pipeline, buffers returned words in a FIFO and
// hands them to decode over a valid/ready handshake. Redirects squash all
// wrong-path words in flight and buffered.
//   clk, rst                   : clock, synchronous active-low reset
//   start, halt                : run control
//   redirect_valid/redirect_pc : branch/jump target load
//   busy                       : state is RUN or DRAIN
//   bus (master)               : imem_* and ins_* signals
//
// state   | meaning
// IDLE    | after reset, waiting for start, redirects ignored
// RUN     | issuing fetches while credit allows
// DRAIN   | no new issue, waiting for in-flight and buffered words to leave
// HALTED  | stopped, pc kept; start resumes from it
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                MEM_LAT   = DEF_MEM_LAT,
    parameter int                PC_STEP   = DEF_PC_STEP,
    parameter int                BUF_DEPTH = DEF_BUF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    fetch_controller_if.master bus
);

    localparam int CNT_W = cnt_width(BUF_DEPTH);
    localparam int ENT_W = DATA_W + ADDR_W;

    fetch_state_e      state_q;
    logic              busy_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [MEM_LAT-1:0] pv_q;
    logic [ADDR_W-1:0] ppc_q [MEM_LAT];
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [ENT_W-1:0]  head;
    logic              redir, credit_ok, issue, ret_valid, ins_valid, pop;

    assign redir     = redirect_valid && (state_q != S_IDLE);
    // Words in flight plus words buffered never exceed the FIFO depth.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(BUF_DEPTH);
    assign issue     = (state_q == S_RUN) && credit_ok && !redir;
    assign ret_valid = pv_q[MEM_LAT-1];
    assign ins_valid = (fifo_cnt != '0);
    assign pop       = ins_valid && bus.ins_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                end
                S_RUN: if (halt) state_q <= S_DRAIN;
                S_DRAIN: if (redir || (inflight_q == '0 && fifo_cnt == '0)) begin
                    state_q <= S_HALTED;
                    busy_q  <= 1'b0;
                end
                S_HALTED: if (start) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret_valid);
        if (redir) begin
            pc_d       = redirect_pc;
            inflight_d = '0;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    // Stage k of the shift pipe holds the fetch issued k+1 cycles ago.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            pv_q       <= '0;
            for (int k = 0; k < MEM_LAT; k++) ppc_q[k] <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            pv_q[0]    <= issue;
            ppc_q[0]   <= pc_q;
            for (int k = 1; k < MEM_LAT; k++) begin
                pv_q[k]  <= pv_q[k-1];
                ppc_q[k] <= ppc_q[k-1];
            end
            if (redir) pv_q <= '0;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ret_valid),
        .pop_i   (pop),
        .flush_i (redir),
        .wdata_i ({bus.imem_rdata, ppc_q[MEM_LAT-1]}),
        .rdata_o (head),
        .count_o (fifo_cnt)
    );

    assign bus.imem_pc   = pc_q;
    assign bus.ins_valid = ins_valid;
    assign bus.ins_data  = ins_valid ? head[ENT_W-1 -: DATA_W] : '0;
    assign bus.ins_pc    = ins_valid ? head[ADDR_W-1:0] : '0;
    assign busy          = busy_q;

endmodule
